// File: rtl/lut_coeff_loader.sv
`timescale 1ns/1ps
// lut_coeff_loader
//   Runtime loader for one interpolation coefficient table held in a
//   single-port block RAM. A start pulse opens a load: DEPTH words are
//   accepted over a valid/ready stream and written sequentially from
//   address 0, while a running write sum is kept. The whole table is then
//   read back, one read per cycle, and the returned words are summed. The
//   load finishes in DONE when both sums agree and in ERROR when they do not.
//   While a load is in flight the force-evaluation pipeline is held off.
//
// Ports
//   clock        sole clock
//   rst_n        asynchronous active-low reset
//   start        single-cycle load request, acted on only when not busy
//   in_data      coefficient word
//   in_valid     in_data is valid
//   in_ready     loader accepts a word this cycle (high throughout WRITE)
//   lut_address  to LUT address
//   lut_data     to LUT write data
//   lut_wren     to LUT write enable
//   lut_rden     to LUT read enable
//   lut_q        from LUT read data, valid READ_LAT cycles after a read
//   busy         a load is in the WRITE or VERIFY phase
//   pipe_hold    stall request to the force pipeline, same as busy
//   done         sticky, readback matched
//   error        sticky, readback mismatched
//   checksum     write-side sum modulo 2^DATA_WIDTH
module lut_coeff_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 3584,
  parameter int ADDR_WIDTH = 12,
  parameter int READ_LAT   = 2
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] lut_address,
  output logic [DATA_WIDTH-1:0] lut_data,
  output logic                  lut_wren,
  output logic                  lut_rden,
  input  logic [DATA_WIDTH-1:0] lut_q,
  output logic                  busy,
  output logic                  pipe_hold,
  output logic                  done,
  output logic                  error,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_VERIFY,
    ST_DONE,
    ST_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  issued_all_q, issued_all_d;
  logic [ADDR_WIDTH-1:0] rcv_cnt_q, rcv_cnt_d;
  logic [DATA_WIDTH-1:0] wr_sum_q, wr_sum_d;
  logic [DATA_WIDTH-1:0] rd_sum_q, rd_sum_d;
  logic [READ_LAT-1:0]   tag_q, tag_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  wren_q, wren_d;
  logic                  rden_q, rden_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  // Tag pipe input is the registered read enable, i.e. the read actually
  // presented to the RAM this cycle. The extra bit makes the shift legal
  // for READ_LAT = 1 as well.
  logic [READ_LAT:0]     tag_ext;
  logic [DATA_WIDTH-1:0] rd_sum_nxt;

  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    issued_all_d = issued_all_q;
    rcv_cnt_d    = rcv_cnt_q;
    wr_sum_d     = wr_sum_q;
    rd_sum_d     = rd_sum_q;
    addr_d       = addr_q;
    data_d       = data_q;
    wren_d       = 1'b0;
    rden_d       = 1'b0;
    done_d       = done_q;
    error_d      = error_q;
    tag_ext      = {tag_q, rden_q};
    tag_d        = tag_ext[READ_LAT-1:0];
    rd_sum_nxt   = rd_sum_q + lut_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d      = ST_WRITE;
          wr_addr_d    = '0;
          rd_addr_d    = '0;
          issued_all_d = 1'b0;
          rcv_cnt_d    = '0;
          wr_sum_d     = '0;
          rd_sum_d     = '0;
          done_d       = 1'b0;
          error_d      = 1'b0;
          tag_d        = '0;
        end
      end

      ST_WRITE: begin
        if (in_valid && in_ready) begin
          addr_d   = wr_addr_q;
          data_d   = in_data;
          wren_d   = 1'b1;
          wr_sum_d = wr_sum_q + in_data;
          // The last word leaves wr_addr parked at LAST_ADDR.
          if (wr_addr_q == LAST_ADDR) begin
            state_d = ST_VERIFY;
          end else begin
            wr_addr_d = wr_addr_q + 1'b1;
          end
        end
      end

      ST_VERIFY: begin
        // The first VERIFY cycle still presents the final write, so the
        // first read registered here lands one cycle later with no overlap.
        if (!issued_all_q) begin
          rden_d = 1'b1;
          addr_d = rd_addr_q;
          if (rd_addr_q == LAST_ADDR) begin
            issued_all_d = 1'b1;
          end else begin
            rd_addr_d = rd_addr_q + 1'b1;
          end
        end
        if (tag_q[READ_LAT-1]) begin
          rd_sum_d = rd_sum_nxt;
          // The final return is folded in combinationally so the verdict
          // is registered in the same edge that samples it.
          if (rcv_cnt_q == LAST_ADDR) begin
            if (rd_sum_nxt == wr_sum_q) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_ERROR;
              error_d = 1'b1;
            end
          end else begin
            rcv_cnt_d = rcv_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      issued_all_q <= 1'b0;
      rcv_cnt_q    <= '0;
      wr_sum_q     <= '0;
      rd_sum_q     <= '0;
      tag_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      wren_q       <= 1'b0;
      rden_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      issued_all_q <= issued_all_d;
      rcv_cnt_q    <= rcv_cnt_d;
      wr_sum_q     <= wr_sum_d;
      rd_sum_q     <= rd_sum_d;
      tag_q        <= tag_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      wren_q       <= wren_d;
      rden_q       <= rden_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign in_ready    = (state_q == ST_WRITE);
  assign busy        = (state_q == ST_WRITE) || (state_q == ST_VERIFY);
  assign pipe_hold   = busy;
  assign lut_address = addr_q;
  assign lut_data    = data_q;
  assign lut_wren    = wren_q;
  assign lut_rden    = rden_q;
  assign done        = done_q;
  assign error       = error_q;
  assign checksum    = wr_sum_q;

endmodule

// File: tb/tb_lut_coeff_loader.sv
`timescale 1ns/1ps
module tb_lut_coeff_loader;

  localparam int DEPTH = 3584;
  localparam int RL    = 2;
  localparam int S_DEPTH = 16;
  localparam int S_RL    = 1;

  int checks = 0;
  int errors = 0;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic rst_n;

  // main instance
  logic        start, in_valid, in_ready, lut_wren, lut_rden, busy, pipe_hold, done, error;
  logic [31:0] in_data, lut_data, lut_q, checksum;
  logic [11:0] lut_address;

  lut_coeff_loader #(.DATA_WIDTH(32), .DEPTH(DEPTH), .ADDR_WIDTH(12), .READ_LAT(RL)) dut (
    .clock(clock), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .lut_address(lut_address), .lut_data(lut_data), .lut_wren(lut_wren),
    .lut_rden(lut_rden), .lut_q(lut_q), .busy(busy), .pipe_hold(pipe_hold), .done(done),
    .error(error), .checksum(checksum)
  );

  // small instance
  logic        s_start, s_in_valid, s_in_ready, s_lut_wren, s_lut_rden, s_busy, s_pipe_hold, s_done, s_error;
  logic [31:0] s_in_data, s_lut_data, s_lut_q, s_checksum;
  logic [3:0]  s_lut_address;

  lut_coeff_loader #(.DATA_WIDTH(32), .DEPTH(S_DEPTH), .ADDR_WIDTH(4), .READ_LAT(S_RL)) dut_s (
    .clock(clock), .rst_n(rst_n), .start(s_start), .in_data(s_in_data), .in_valid(s_in_valid),
    .in_ready(s_in_ready), .lut_address(s_lut_address), .lut_data(s_lut_data), .lut_wren(s_lut_wren),
    .lut_rden(s_lut_rden), .lut_q(s_lut_q), .busy(s_busy), .pipe_hold(s_pipe_hold), .done(s_done),
    .error(s_error), .checksum(s_checksum)
  );

  // LUT models: M20K with output register (2 cycles) and a 1-cycle variant
  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] rd_s1;
  bit          corrupt = 1'b0;
  always @(posedge clock) begin
    if (lut_wren) mem[lut_address] <= lut_data;
    if (lut_rden) rd_s1 <= (corrupt && lut_address == 12'd100) ? (mem[lut_address] ^ 32'h1) : mem[lut_address];
    lut_q <= rd_s1;
  end

  logic [31:0] s_mem [0:S_DEPTH-1];
  always @(posedge clock) begin
    if (s_lut_wren) s_mem[s_lut_address] <= s_lut_data;
    if (s_lut_rden) s_lut_q <= s_mem[s_lut_address];
  end

  // write and read enables must never be high together
  always @(negedge clock) begin
    if (lut_wren || lut_rden) begin
      checks++;
      assert (!(lut_wren && lut_rden)) else begin
        errors++;
        $display("FAIL wr_rd_overlap main got wren=%b rden=%b required not both", lut_wren, lut_rden);
      end
    end
    if (s_lut_wren || s_lut_rden) begin
      checks++;
      assert (!(s_lut_wren && s_lut_rden)) else begin
        errors++;
        $display("FAIL wr_rd_overlap small got wren=%b rden=%b required not both", s_lut_wren, s_lut_rden);
      end
    end
  end

  // scoreboard of expected LUT writes {address, data}
  logic [43:0] wr_q [$];
  logic [31:0] exp_sum;

  // One load on the main instance. Writes are scoreboarded per handshake;
  // the verify phase is checked cycle by cycle against the documented timing.
  task automatic run_load(input bit rnd, input int start_at_word, input int start_at_verify,
                          input bit ok, input int stop_after);
    int          i, guard, fin;
    bit          hs, hs_prev, pulsed;
    logic [43:0] exp_w;
    logic [6:0]  exp_v, got_v;
    i = 0; guard = 0; hs_prev = 1'b0; pulsed = 1'b0; fin = DEPTH + 2 + RL;
    wr_q.delete();
    exp_sum = '0;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    checks++;
    if ({in_ready, busy, pipe_hold, done, error} !== 5'b11100 || checksum !== 32'h0) begin
      errors++;
      $display("FAIL start_state got rdy/busy/hold/done/err=%b sum=%h required 11100 sum=0",
               {in_ready, busy, pipe_hold, done, error}, checksum);
    end
    $display("load start rnd=%0d ok=%0d", rnd, ok);
    while (i < DEPTH) begin
      checks++;
      if (lut_wren !== hs_prev) begin
        errors++;
        $display("FAIL wren_timing word=%0d got %b required %b", i, lut_wren, hs_prev);
      end
      if (lut_wren === 1'b1 && wr_q.size() != 0) begin
        exp_w = wr_q.pop_front();
        checks++;
        if ({lut_address, lut_data} !== exp_w) begin
          errors++;
          $display("FAIL write_data got a=%0d d=%h required a=%0d d=%h",
                   lut_address, lut_data, exp_w[43:32], exp_w[31:0]);
        end
      end
      if (i == stop_after) return;
      start = (!pulsed && i == start_at_word);
      if (start) pulsed = 1'b1;
      in_valid = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      in_data  = 32'(i);
      hs = in_valid && in_ready;
      if (hs) begin
        wr_q.push_back({12'(i), 32'(i)});
        exp_sum = exp_sum + 32'(i);
        i++;
      end
      hs_prev = hs;
      @(negedge clock);
      guard++;
      if (guard > 30000) begin
        errors++;
        $display("FAIL write_timeout accepted %0d required %0d", i, DEPTH);
        in_valid = 1'b0; start = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    start = 1'b0;
    checks++;
    if (checksum !== exp_sum) begin
      errors++;
      $display("FAIL checksum got %h required %h", checksum, exp_sum);
    end
    for (int n = 1; n <= fin; n++) begin
      if (lut_wren === 1'b1) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL write_extra n=%0d got wren=1 required no pending write", n);
        end else begin
          exp_w = wr_q.pop_front();
          if ({lut_address, lut_data} !== exp_w) begin
            errors++;
            $display("FAIL write_data got a=%0d d=%h required a=%0d d=%h",
                     lut_address, lut_data, exp_w[43:32], exp_w[31:0]);
          end
        end
      end
      exp_v = {n == 1, n >= 2 && n <= DEPTH + 1, n == fin && ok, n == fin && !ok,
               n != fin, n != fin, 1'b0};
      got_v = {lut_wren, lut_rden, done, error, busy, pipe_hold, in_ready};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL verify_ctrl n=%0d got wr/rd/done/err/busy/hold/rdy=%b required %b", n, got_v, exp_v);
      end
      if (exp_v[5] && lut_address !== 12'(n - 2)) begin
        errors++;
        $display("FAIL read_addr n=%0d got %0d required %0d", n, lut_address, n - 2);
      end
      start = (n == start_at_verify);
      if (n < fin) @(negedge clock);
    end
    start = 1'b0;
    checks++;
    if (wr_q.size() != 0) begin
      errors++;
      $display("FAIL write_missing got %0d pending required 0", wr_q.size());
    end
    $display("load end done=%b error=%b checksum=%h", done, error, checksum);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    s_start = 1'b0; s_in_valid = 1'b0; s_in_data = '0;
    #12;
    checks++;
    if ({in_ready, lut_address, lut_data, lut_wren, lut_rden, busy, pipe_hold, done, error, checksum} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got nonzero (rdy=%b busy=%b done=%b err=%b sum=%h) required all 0",
               in_ready, busy, done, error, checksum);
    end
    @(negedge clock); rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_full_load();
    int bad;
    run_load(1'b0, -1, -1, 1'b1, -1);
    bad = 0;
    for (int a = 0; a < DEPTH; a++) if (mem[a] !== 32'(a)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL full_contents got %0d bad words required 0", bad); end
    checks++;
    if (checksum !== 32'h0061F900) begin
      errors++; $display("FAIL full_checksum got %h required 0061f900", checksum);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    for (int a = 0; a < DEPTH; a++) mem[a] = 32'hDEAD_BEEF;
    run_load(1'b1, -1, -1, 1'b1, -1);
    bad = 0;
    for (int a = 0; a < DEPTH; a++) if (mem[a] !== 32'(a)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_contents got %0d bad words required 0", bad); end
    checks++;
    if (checksum !== 32'h0061F900) begin
      errors++; $display("FAIL bp_checksum got %h required 0061f900", checksum);
    end
  endtask

  task automatic test_corrupt();
    corrupt = 1'b1;
    run_load(1'b0, -1, -1, 1'b0, -1);
    repeat (5) @(negedge clock);
    checks++;
    if ({error, done, busy, in_ready} !== 4'b1000) begin
      errors++; $display("FAIL corrupt_hold got err/done/busy/rdy=%b required 1000", {error, done, busy, in_ready});
    end
    corrupt = 1'b0;
  endtask

  task automatic test_start_while_busy();
    run_load(1'b0, 500, 100, 1'b1, -1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      checks++;
      if ({done, error, busy} !== 3'b100 || checksum !== 32'h0061F900) begin
        errors++;
        $display("FAIL busy_start_after got done/err/busy=%b sum=%h required 100 sum=0061f900",
                 {done, error, busy}, checksum);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    run_load(1'b0, -1, -1, 1'b1, 1000);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, lut_address, lut_data, lut_wren, lut_rden, busy, pipe_hold, done, error, checksum} !== '0) begin
      errors++;
      $display("FAIL midload_reset got rdy=%b wren=%b busy=%b sum=%h required all 0",
               in_ready, lut_wren, busy, checksum);
    end
    @(negedge clock); rst_n = 1'b1;
    $display("reset mid-load applied");
    test_full_load();
  endtask

  task automatic test_small_depth();
    int cnt, g, n, bad;
    logic [31:0] s_sum;
    cnt = 0; g = 0; n = 1; s_sum = '0;
    @(negedge clock); s_start = 1'b1;
    @(negedge clock); s_start = 0;
    s_in_valid = 1'b1; s_in_data = 32'hFFFF_FFFF;
    while (cnt < S_DEPTH && g < 100) begin
      if (s_in_ready) begin cnt++; s_sum = s_sum + s_in_data; end
      @(negedge clock);
      g++;
    end
    s_in_valid = 1'b0;
    while (!s_done && !s_error && n < 60) begin @(negedge clock); n++; end
    checks++;
    if (n != S_DEPTH + 2 + S_RL) begin
      errors++; $display("FAIL small_latency got %0d required %0d", n, S_DEPTH + 2 + S_RL);
    end
    checks++;
    if ({s_done, s_error, s_busy} !== 3'b100 || s_checksum !== 32'hFFFF_FFF0 || s_checksum !== s_sum) begin
      errors++;
      $display("FAIL small_result got done/err/busy=%b sum=%h required 100 sum=fffffff0 (model %h)",
               {s_done, s_error, s_busy}, s_checksum, s_sum);
    end
    bad = 0;
    for (int a = 0; a < S_DEPTH; a++) if (s_mem[a] !== 32'hFFFF_FFFF) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL small_contents got %0d bad words required 0", bad); end
    $display("small load done=%b checksum=%h", s_done, s_checksum);
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_backpressure();
    test_corrupt();
    test_start_while_busy();
    test_reset_mid_load();
    test_small_depth();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
